// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin front end for a single combinational ALU.
// Each port hands over one operation per grant, and the result lands in that
// port's response register on the grant edge. The response is held there until
// the port's consumer takes it.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    input  logic             r1_valid,
    output logic             r0_ready,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r0_src1,
    input  logic [WIDTH-1:0] r0_src2,
    input  logic [WIDTH-1:0] r1_src1,
    input  logic [WIDTH-1:0] r1_src2,
    input  logic [OPW-1:0]   r0_op,
    input  logic [OPW-1:0]   r1_op,
    output logic             r0_resp_valid,
    output logic             r1_resp_valid,
    input  logic             r0_resp_ready,
    input  logic             r1_resp_ready,
    output logic [WIDTH-1:0] r0_result,
    output logic [WIDTH-1:0] r1_result,
    output logic             r0_zero,
    output logic             r1_zero,
    output logic [WIDTH-1:0] alu_src1,
    output logic [WIDTH-1:0] alu_src2,
    output logic [OPW-1:0]   alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    // last_grant_q: 0 = r0 was granted last, 1 = r1 (reset value lets r0 win first)
    logic             last_grant_q, last_grant_d;
    logic             e0, e1, gnt0, gnt1;
    logic             r0_vld_q, r0_vld_d, r1_vld_q, r1_vld_d;
    logic [WIDTH-1:0] r0_res_q, r0_res_d, r1_res_q, r1_res_d;
    logic             r0_zero_q, r0_zero_d, r1_zero_q, r1_zero_d;

    // Eligibility and round-robin pick; a slot being drained this cycle may refill.
    always_comb begin
        e0   = r0_valid && (!r0_vld_q || r0_resp_ready) && !rst;
        e1   = r1_valid && (!r1_vld_q || r1_resp_ready) && !rst;
        gnt0 = e0 && (!e1 || last_grant_q);
        gnt1 = e1 && !gnt0;
        last_grant_d = last_grant_q;
        if (gnt0) last_grant_d = 1'b0;
        if (gnt1) last_grant_d = 1'b1;
    end

    // Drive the ALU from the winner; idle drives a known opcode that yields 0.
    always_comb begin
        alu_src1    = '0;
        alu_src2    = '0;
        alu_control = '1;
        if (gnt0) begin
            alu_src1    = r0_src1;
            alu_src2    = r0_src2;
            alu_control = r0_op;
        end else if (gnt1) begin
            alu_src1    = r1_src1;
            alu_src2    = r1_src2;
            alu_control = r1_op;
        end
    end

    // Response slots: a grant captures (and wins over a drain), a drain alone empties.
    always_comb begin
        r0_vld_d  = r0_vld_q;
        r0_res_d  = r0_res_q;
        r0_zero_d = r0_zero_q;
        r1_vld_d  = r1_vld_q;
        r1_res_d  = r1_res_q;
        r1_zero_d = r1_zero_q;
        if (gnt0) begin
            r0_vld_d  = 1'b1;
            r0_res_d  = alu_result;
            r0_zero_d = alu_zero;
        end else if (r0_vld_q && r0_resp_ready) begin
            r0_vld_d  = 1'b0;
        end
        if (gnt1) begin
            r1_vld_d  = 1'b1;
            r1_res_d  = alu_result;
            r1_zero_d = alu_zero;
        end else if (r1_vld_q && r1_resp_ready) begin
            r1_vld_d  = 1'b0;
        end
    end

    // State registers; reset discards any pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            r0_vld_q     <= 1'b0;
            r0_res_q     <= '0;
            r0_zero_q    <= 1'b0;
            r1_vld_q     <= 1'b0;
            r1_res_q     <= '0;
            r1_zero_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            r0_vld_q     <= r0_vld_d;
            r0_res_q     <= r0_res_d;
            r0_zero_q    <= r0_zero_d;
            r1_vld_q     <= r1_vld_d;
            r1_res_q     <= r1_res_d;
            r1_zero_q    <= r1_zero_d;
        end
    end

    assign r0_ready      = gnt0;
    assign r1_ready      = gnt1;
    assign r0_resp_valid = r0_vld_q;
    assign r1_resp_valid = r1_vld_q;
    assign r0_result     = r0_res_q;
    assign r1_result     = r1_res_q;
    assign r0_zero       = r0_zero_q;
    assign r1_zero       = r1_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: random and directed stimulus against a cycle-level reference
// model of the arbiter's rules; a behavioural ALU sits on the ALU ports.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        v[2], rdy[2], rr[2], rv[2], zf[2];
    logic [31:0] s1[2], s2[2], res[2];
    logic [2:0]  op[2];
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic [2:0]  alu_control;
    logic        alu_zero;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic        m_vld[2];
    logic [31:0] m_res[2];
    logic        m_zero[2];
    int          m_last;
    logic        obs_rdy[2];
    logic        lg[2];
    int          alt_prev;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .OPW(3)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(v[0]), .r1_valid(v[1]),
        .r0_ready(rdy[0]), .r1_ready(rdy[1]),
        .r0_src1(s1[0]), .r0_src2(s2[0]), .r1_src1(s1[1]), .r1_src2(s2[1]),
        .r0_op(op[0]), .r1_op(op[1]),
        .r0_resp_valid(rv[0]), .r1_resp_valid(rv[1]),
        .r0_resp_ready(rr[0]), .r1_resp_ready(rr[1]),
        .r0_result(res[0]), .r1_result(res[1]),
        .r0_zero(zf[0]), .r1_zero(zf[1]),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    // behavioural ALU on the arbiter's ALU port
    always_comb begin
        alu_result = 32'd0;
        case (alu_control)
            3'b000: alu_result = alu_src1 + alu_src2;
            3'b001: alu_result = alu_src1 - alu_src2;
            3'b010: alu_result = alu_src1 & alu_src2;
            3'b011: alu_result = alu_src1 | alu_src2;
            3'b101: alu_result = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    function automatic logic [31:0] ref_alu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock cycle: check grant/ALU drive before the edge, then model and outputs after it.
    task automatic step();
        logic e[2];
        logic g[2];
        logic [31:0] nr;
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            e[i] = v[i] && (!m_vld[i] || rr[i]) && !rst;
        g[0] = e[0] && (!e[1] || m_last == 1);
        g[1] = e[1] && !g[0];
        obs_rdy[0] = rdy[0];
        obs_rdy[1] = rdy[1];
        check("r0_ready", 32'(rdy[0]), 32'(g[0]));
        check("r1_ready", 32'(rdy[1]), 32'(g[1]));
        if (!g[0] && !g[1]) begin
            check("idle_ctl", 32'(alu_control), 32'd7);
            check("idle_src", alu_src1 | alu_src2, 32'd0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_vld[i] = 1'b0; m_res[i] = '0; m_zero[i] = 1'b0;
            end else if (g[i]) begin
                nr = ref_alu(op[i], s1[i], s2[i]);
                m_vld[i] = 1'b1; m_res[i] = nr; m_zero[i] = (nr == 32'd0);
            end else if (m_vld[i] && rr[i]) begin
                m_vld[i] = 1'b0;
            end
            lg[i] = g[i];
        end
        if (rst) m_last = 1;
        else if (g[0]) m_last = 0;
        else if (g[1]) m_last = 1;
        check("r0_resp_valid", 32'(rv[0]), 32'(m_vld[0]));
        check("r1_resp_valid", 32'(rv[1]), 32'(m_vld[1]));
        check("r0_result", res[0], m_res[0]);
        check("r1_result", res[1], m_res[1]);
        check("r0_zero", 32'(zf[0]), 32'(m_zero[0]));
        check("r1_zero", 32'(zf[1]), 32'(m_zero[1]));
    endtask

    task automatic new_req(input int i);
        op[i] = 3'($urandom_range(0, 7));
        s1[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        s2[i] = ($urandom_range(0, 3) == 0) ? s1[i] : $urandom;
    endtask

    task automatic set_req(input int i, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        v[i] = 1'b1; op[i] = o; s1[i] = a; s2[i] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [31:0] saved;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b1; rr[i] = 1'b1; s1[i] = 32'd1; s2[i] = 32'd2; op[i] = 3'd0;
            m_vld[i] = 1'b0; m_res[i] = '0; m_zero[i] = 1'b0; lg[i] = 1'b0;
        end
        m_last = 1;
        // reset with requests present: no grants, outputs cleared
        step();
        step();
        rst = 1'b0;
        v[0] = 1'b0; v[1] = 1'b0;

        // single ADD on r0
        set_req(0, 3'd0, 32'd5, 32'd7);
        step();
        check("add_rdy", 32'(obs_rdy[0]), 32'd1);
        check("add_res", res[0], 32'd12);
        check("add_zero", 32'(zf[0]), 32'd0);
        v[0] = 1'b0;

        // r1 SUB to zero, then SLT -1 < 1
        set_req(1, 3'd1, 32'd12345, 32'd12345);
        step();
        check("sub_res", res[1], 32'd0);
        check("sub_zero", 32'(zf[1]), 32'd1);
        set_req(1, 3'd5, 32'hFFFF_FFFF, 32'd1);
        step();
        check("slt_res", res[1], 32'd1);
        v[1] = 1'b0;
        step();

        // contention: alternate grants starting with r0, 1000 random ops
        do_reset();
        v[0] = 1'b1; v[1] = 1'b1; rr[0] = 1'b1; rr[1] = 1'b1;
        new_req(0); new_req(1);
        alt_prev = 1;
        for (int n = 0; n < 1000; n++) begin
            step();
            check("alternate", 32'(obs_rdy[0]), 32'(alt_prev == 1));
            alt_prev = obs_rdy[0] ? 0 : 1;
            for (int i = 0; i < 2; i++) if (lg[i]) new_req(i);
        end

        // back-pressure on r0
        v[1] = 1'b0;
        rr[0] = 1'b1;
        set_req(0, 3'd3, 32'hA0, 32'h0B);
        step();
        saved = res[0];
        check("bp_fill", saved, 32'hAB);
        rr[0] = 1'b0;
        set_req(0, 3'd0, 32'd1, 32'd1);
        set_req(1, 3'd2, 32'hFF, 32'h0F);
        for (int n = 0; n < 4; n++) begin
            step();
            check("bp_r0_blocked", 32'(obs_rdy[0]), 32'd0);
            check("bp_r1_granted", 32'(obs_rdy[1]), 32'd1);
            check("bp_hold", res[0], saved);
        end
        rr[0] = 1'b1;
        step();
        check("bp_release", 32'(obs_rdy[0]), 32'd1);
        check("bp_new", res[0], 32'd2);
        v[0] = 1'b0; v[1] = 1'b0;
        step();

        // drain and refill back-to-back on r0
        set_req(0, 3'd0, 32'd1, 32'd1);
        step();
        check("dr_res1", res[0], 32'd2);
        set_req(0, 3'd0, 32'd2, 32'd2);
        step();
        check("dr_rdy2", 32'(obs_rdy[0]), 32'd1);
        check("dr_vld2", 32'(rv[0]), 32'd1);
        check("dr_res2", res[0], 32'd4);

        // reset in the cycle after a grant
        set_req(0, 3'd0, 32'd9, 32'd9);
        step();
        rst = 1'b1;
        step();
        check("rst_vld", 32'(rv[0]), 32'd0);
        check("rst_res", res[0], 32'd0);
        step();
        rst = 1'b0;
        v[0] = 1'b0;
        step();

        // free-running random traffic with back-pressure and occasional reset
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (lg[i] || !v[i]) begin
                    v[i] = ($urandom_range(0, 3) != 0);
                    new_req(i);
                end
                rr[i] = ($urandom_range(0, 2) != 0);
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
